// File: rtl/branch_resolve_pkg.sv
// Shared constants for branch resolution: RV32 opcodes, branch funct3 codes, bus widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_resolve_pkg;

    localparam int InstAddrBus = 32;
    localparam int RegBus      = 32;

    localparam logic [InstAddrBus-1:0] ZeroWord = 32'h0000_0000;

    // RV32I control-transfer opcodes
    localparam logic [6:0] RV_OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] RV_OP_JAL    = 7'b110_1111;
    localparam logic [6:0] RV_OP_JALR   = 7'b110_0111;

    // Branch condition encodings in funct3
    localparam logic [2:0] RV_F3_BEQ  = 3'b000;
    localparam logic [2:0] RV_F3_BNE  = 3'b001;
    localparam logic [2:0] RV_F3_BLT  = 3'b100;
    localparam logic [2:0] RV_F3_BGE  = 3'b101;
    localparam logic [2:0] RV_F3_BLTU = 3'b110;
    localparam logic [2:0] RV_F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: actual taken bit from funct3 and the two operands.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the result with its own valid/stall.
module branch_cmp
    import branch_resolve_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [RegBus-1:0] rs1_data_i,
    input  logic [RegBus-1:0] rs2_data_i,
    output logic              taken_o
);

    // Undefined funct3 encodings evaluate to not-taken.
    always_comb begin
        taken_o = 1'b0;
        unique case (funct3_i)
            RV_F3_BEQ:  taken_o = (rs1_data_i == rs2_data_i);
            RV_F3_BNE:  taken_o = (rs1_data_i != rs2_data_i);
            RV_F3_BLT:  taken_o = ($signed(rs1_data_i) <  $signed(rs2_data_i));
            RV_F3_BGE:  taken_o = ($signed(rs1_data_i) >= $signed(rs2_data_i));
            RV_F3_BLTU: taken_o = (rs1_data_i <  rs2_data_i);
            RV_F3_BGEU: taken_o = (rs1_data_i >= rs2_data_i);
            default:    taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolver: compares actual outcome with IF prediction, redirects PC and flushes IF/ID.
// Latency: mispredict seen in cycle N -> redirect_o/flush_o in N+1; flush_o lasts FLUSH_CYCLES non-stalled cycles.
// Backpressure: stall_i blocks new resolutions and freezes the flush countdown. Optional macro BRU_PERF_CNT_EN enables perf counters.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   valid_i,
    input  logic [6:0]             opcode_i,
    input  logic [2:0]             funct3_i,
    input  logic [InstAddrBus-1:0] pc_i,
    input  logic [31:0]            imm_i,
    input  logic [RegBus-1:0]      rs1_data_i,
    input  logic [RegBus-1:0]      rs2_data_i,
    input  logic                   prdt_taken_i,
    input  logic [InstAddrBus-1:0] prdt_target_address_i,
    output logic                   redirect_o,
    output logic [InstAddrBus-1:0] redirect_pc_o,
    output logic                   flush_o,
    output logic [31:0]            branch_cnt_o,
    output logic [31:0]            mispredict_cnt_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   redirect_q, redirect_d;
    logic [InstAddrBus-1:0] redirect_pc_q, redirect_pc_d;

    logic                   cmp_taken;
    logic                   act_taken;
    logic [InstAddrBus-1:0] act_target;
    logic [InstAddrBus-1:0] jalr_sum;
    logic [InstAddrBus-1:0] pc_plus4;
    logic [InstAddrBus-1:0] correct_pc;
    logic                   mispredict;
    logic                   resolve;

    branch_cmp u_branch_cmp (
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .taken_o    (cmp_taken)
    );

    assign jalr_sum = rs1_data_i + imm_i;
    assign pc_plus4 = pc_i + 32'd4;

    // Actual outcome and target; unknown opcodes resolve as not-taken.
    always_comb begin
        act_taken  = 1'b0;
        act_target = pc_i + imm_i;
        unique case (opcode_i)
            RV_OP_BRANCH: act_taken = cmp_taken;
            RV_OP_JAL:    act_taken = 1'b1;
            RV_OP_JALR: begin
                act_taken  = 1'b1;
                act_target = {jalr_sum[InstAddrBus-1:1], 1'b0};
            end
            default:      act_taken = 1'b0;
        endcase
    end

    assign correct_pc = act_taken ? act_target : pc_plus4;
    assign mispredict = (act_taken != prdt_taken_i) ||
                        (act_taken && prdt_taken_i && (act_target != prdt_target_address_i));
    // Only IDLE accepts work; anything valid during FLUSH is wrong-path.
    assign resolve    = (state_q == ST_IDLE) && valid_i && !stall_i;

    // Next-state: launch a flush on mispredict, count it down on non-stalled cycles.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (resolve && mispredict) begin
                    state_d       = ST_FLUSH;
                    cnt_d         = 2'(FLUSH_CYCLES);
                    redirect_d    = 1'b1;
                    redirect_pc_d = correct_pc;
                end
            end
            ST_FLUSH: begin
                if (!stall_i) begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State, flush counter and redirect registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 2'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= ZeroWord;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign flush_o       = (state_q == ST_FLUSH);

`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    // Saturating counters of resolved instructions and mispredicts.
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (resolve && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (resolve && mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`else
    assign branch_cnt_o     = 32'd0;
    assign mispredict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: hand-computed redirect/flush vectors.
// Latency: inputs driven on falling edge, outputs sampled on the following falling edge.
// Backpressure: exercises stall_i in IDLE and during FLUSH.
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] pc_i;
    logic [31:0] imm_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        prdt_taken_i;
    logic [31:0] prdt_target_address_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve #(.FLUSH_CYCLES(2)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .stall_i               (stall_i),
        .valid_i               (valid_i),
        .opcode_i              (opcode_i),
        .funct3_i              (funct3_i),
        .pc_i                  (pc_i),
        .imm_i                 (imm_i),
        .rs1_data_i            (rs1_data_i),
        .rs2_data_i            (rs2_data_i),
        .prdt_taken_i          (prdt_taken_i),
        .prdt_target_address_i (prdt_target_address_i),
        .redirect_o            (redirect_o),
        .redirect_pc_o         (redirect_pc_o),
        .flush_o               (flush_o),
        .branch_cnt_o          (branch_cnt_o),
        .mispredict_cnt_o      (mispredict_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                         input logic pt, input logic [31:0] ptgt);
        valid_i = 1'b1; opcode_i = op; funct3_i = f3; pc_i = pc; imm_i = imm;
        rs1_data_i = a; rs2_data_i = b; prdt_taken_i = pt; prdt_target_address_i = ptgt;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
        drive(7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b want 0", redirect_o); end
        n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush_o); end
        n_checks++; if (redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", redirect_pc_o); end
        n_checks++; if (branch_cnt_o !== 32'h0 || mispredict_cnt_o !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h/%h want 0/0", branch_cnt_o, mispredict_cnt_o); end
        rst = 1'b1;
    endtask

    task automatic test_beq_correct();
        @(negedge clk);
        drive(RV_OP_BRANCH, RV_F3_BEQ, 32'h100, 32'hFFFF_FFF0, 32'h55, 32'h55, 1'b1, 32'hF0);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL beq_redirect: got %b want 0", redirect_o); end
        n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL beq_flush: got %b want 0", flush_o); end
        n_checks++; if (redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL beq_pc: got %h want 0", redirect_pc_o); end
    endtask

    task automatic test_bne_mispredict();
        @(negedge clk);
        drive(RV_OP_BRANCH, RV_F3_BNE, 32'h200, 32'h100, 32'h5, 32'h5, 1'b1, 32'h300);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b1) begin n_fail++; $display("FAIL bne_redirect: got %b want 1", redirect_o); end
        n_checks++; if (redirect_pc_o !== 32'h204) begin n_fail++; $display("FAIL bne_pc: got %h want 204", redirect_pc_o); end
        n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL bne_flush1: got %b want 1", flush_o); end
        @(negedge clk);
        n_checks++; if (redirect_o !== 1'b0) begin n_fail++; $display("FAIL bne_redirect_pulse: got %b want 0", redirect_o); end
        n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL bne_flush2: got %b want 1", flush_o); end
        @(negedge clk);
        n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL bne_flush_end: got %b want 0", flush_o); end
        n_checks++; if (redirect_pc_o !== 32'h204) begin n_fail++; $display("FAIL bne_pc_hold: got %h want 204", redirect_pc_o); end
    endtask

    task automatic test_jalr_wrong_path();
        @(negedge clk);
        drive(RV_OP_JALR, 3'b000, 32'h800, 32'h4, 32'h1001, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h1004) begin n_fail++; $display("FAIL jalr_redirect: got %b/%h want 1/1004", redirect_o, redirect_pc_o); end
        // wrong-path mispredicting branch while flushing
        drive(RV_OP_BRANCH, RV_F3_BNE, 32'h500, 32'h10, 32'h7, 32'h7, 1'b1, 32'h510);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h1004) begin n_fail++; $display("FAIL jalr_wrongpath: got %b/%h want 0/1004", redirect_o, redirect_pc_o); end
        @(negedge clk);
        n_checks++; if (flush_o !== 1'b0 || redirect_o !== 1'b0) begin n_fail++; $display("FAIL jalr_flush_end: got flush %b redirect %b want 0/0", flush_o, redirect_o); end
    endtask

    task automatic test_stall_flush();
        int n_red;
        int n_fl;
        @(negedge clk);
        drive(RV_OP_BRANCH, RV_F3_BLT, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h340) begin n_fail++; $display("FAIL blt_redirect: got %b/%h want 1/340", redirect_o, redirect_pc_o); end
        n_red = int'(redirect_o); n_fl = int'(flush_o);
        stall_i = 1'b1;
        for (int i = 2; i <= 7; i++) begin
            @(negedge clk);
            n_red += int'(redirect_o); n_fl += int'(flush_o);
            if (i == 4) stall_i = 1'b0;
        end
        n_checks++; if (n_fl != 5) begin n_fail++; $display("FAIL stall_flush_len: got %0d want 5", n_fl); end
        n_checks++; if (n_red != 1) begin n_fail++; $display("FAIL stall_redirect_len: got %0d want 1", n_red); end
        n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL stall_flush_end: got %b want 0", flush_o); end
    endtask

    task automatic test_compare_variants();
        // BLTU: 0xFFFFFFFF < 1 unsigned is false -> not taken, predicted not taken
        @(negedge clk);
        drive(RV_OP_BRANCH, RV_F3_BLTU, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h340) begin n_fail++; $display("FAIL bltu_none: got %b/%h want 0/340", redirect_o, redirect_pc_o); end
        // BGE signed: -1 >= 1 false, predicted taken -> fall through
        @(negedge clk);
        drive(RV_OP_BRANCH, RV_F3_BGE, 32'h310, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h350);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h314) begin n_fail++; $display("FAIL bge_fallthru: got %b/%h want 1/314", redirect_o, redirect_pc_o); end
        repeat (2) @(negedge clk);
        // BGEU at top of address space: 0 >= 1 false -> pc+4 wraps to 0
        drive(RV_OP_BRANCH, RV_F3_BGEU, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h1, 1'b1, 32'h4);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %b/%h want 1/0", redirect_o, redirect_pc_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_jal_target();
        @(negedge clk);
        drive(RV_OP_JAL, 3'b000, 32'h400, 32'h20, 32'h0, 32'h0, 1'b1, 32'h420);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL jal_correct: got %b/%b want 0/0", redirect_o, flush_o); end
        @(negedge clk);
        drive(RV_OP_JAL, 3'b000, 32'h400, 32'h20, 32'h0, 32'h0, 1'b1, 32'h424);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h420) begin n_fail++; $display("FAIL jal_bad_target: got %b/%h want 1/420", redirect_o, redirect_pc_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_undefined();
        @(negedge clk);
        drive(7'b011_0011, 3'b000, 32'h600, 32'h10, 32'h1, 32'h2, 1'b1, 32'h610);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h604) begin n_fail++; $display("FAIL other_op_pt: got %b/%h want 1/604", redirect_o, redirect_pc_o); end
        repeat (2) @(negedge clk);
        drive(7'b011_0011, 3'b000, 32'h680, 32'h10, 32'h1, 32'h2, 1'b0, 32'h0);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h604) begin n_fail++; $display("FAIL other_op_npt: got %b/%h want 0/604", redirect_o, redirect_pc_o); end
        @(negedge clk);
        drive(RV_OP_BRANCH, 3'b010, 32'h700, 32'h10, 32'h3, 32'h3, 1'b1, 32'h710);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h704) begin n_fail++; $display("FAIL undef_f3: got %b/%h want 1/704", redirect_o, redirect_pc_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall_idle();
        @(negedge clk);
        stall_i = 1'b1;
        drive(RV_OP_BRANCH, RV_F3_BNE, 32'h900, 32'h10, 32'h9, 32'h9, 1'b1, 32'h910);
        @(negedge clk);
        n_checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL stall_idle_block: got %b/%b want 0/0", redirect_o, flush_o); end
        stall_i = 1'b0;
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h904) begin n_fail++; $display("FAIL stall_idle_release: got %b/%h want 1/904", redirect_o, redirect_pc_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        drive(RV_OP_BRANCH, RV_F3_BNE, 32'hA00, 32'h10, 32'h1, 32'h1, 1'b1, 32'hA10);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL midflush_pre: got %b want 1", flush_o); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (flush_o !== 1'b0 || redirect_o !== 1'b0) begin n_fail++; $display("FAIL async_reset: got flush %b redirect %b want 0/0", flush_o, redirect_o); end
        n_checks++; if (redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc: got %h want 0", redirect_pc_o); end
        @(negedge clk);
        rst = 1'b1;
        drive(RV_OP_BRANCH, RV_F3_BNE, 32'hB00, 32'h10, 32'h1, 32'h1, 1'b1, 32'hB10);
        @(negedge clk); valid_i = 1'b0;
        n_checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'hB04) begin n_fail++; $display("FAIL first_after_reset: got %b/%h want 1/b04", redirect_o, redirect_pc_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_counters();
        logic [31:0] exp_br;
        logic [31:0] exp_mp;
`ifdef BRU_PERF_CNT_EN
        exp_br = 32'd3; exp_mp = 32'd1;
`else
        exp_br = 32'd0; exp_mp = 32'd0;
`endif
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        drive(RV_OP_BRANCH, RV_F3_BEQ, 32'h100, 32'hFFFF_FFF0, 32'h2, 32'h2, 1'b1, 32'hF0);
        @(negedge clk);
        drive(RV_OP_BRANCH, RV_F3_BNE, 32'h200, 32'h100, 32'h2, 32'h2, 1'b1, 32'h300);
        @(negedge clk);
        // wrong-path instruction held through FLUSH, resolved once IDLE returns
        drive(RV_OP_BRANCH, RV_F3_BEQ, 32'h100, 32'hFFFF_FFF0, 32'h2, 32'h2, 1'b1, 32'hF0);
        repeat (3) @(negedge clk);
        valid_i = 1'b0;
        n_checks++; if (branch_cnt_o !== exp_br) begin n_fail++; $display("FAIL branch_cnt: got %0d want %0d", branch_cnt_o, exp_br); end
        n_checks++; if (mispredict_cnt_o !== exp_mp) begin n_fail++; $display("FAIL mispredict_cnt: got %0d want %0d", mispredict_cnt_o, exp_mp); end
    endtask

    initial begin
        test_reset();
        test_beq_correct();
        test_bne_mispredict();
        test_jalr_wrong_path();
        test_stall_flush();
        test_compare_variants();
        test_jal_target();
        test_undefined();
        test_stall_idle();
        test_reset_mid_flush();
        test_counters();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
